// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC selection, IF/ID register and RUN/HALT control.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter int unsigned                 DATA_WIDTH = 16,
    parameter int unsigned                 ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]       NOP_INSTR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  stall_IF_ID_i,
    input  logic                  flush_IF_ID_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  stop_i,
    output logic [ADDR_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] instrD_o,
    output logic                  validD_o,
    output logic                  halted_o,
    output logic [15:0]           fetch_cnt_o,
    output logic [15:0]           stall_cnt_o
);

    typedef enum logic {RUN, HALT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;

    assign imem_addr_o = pc;

    // Decision chain order encodes the priorities: branch > stall > stop > jump > sequential.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            halted_o <= 1'b0;
            pc       <= RESET_PC;
            PCD_o    <= '0;
            instrD_o <= NOP_INSTR;
            validD_o <= 1'b0;
        end else if (state == RUN) begin
            if (branch_taken_i) begin
                pc       <= branch_target_i;
                PCD_o    <= '0;
                instrD_o <= NOP_INSTR;
                validD_o <= 1'b0;
            end else if (stall_IF_ID_i) begin
                if (flush_IF_ID_i) begin
                    PCD_o    <= '0;
                    instrD_o <= NOP_INSTR;
                    validD_o <= 1'b0;
                end
            end else if (stop_i) begin
                state    <= HALT;
                halted_o <= 1'b1;
                PCD_o    <= '0;
                instrD_o <= NOP_INSTR;
                validD_o <= 1'b0;
            end else if (jump_i) begin
                pc       <= jump_addr_i;
                PCD_o    <= '0;
                instrD_o <= NOP_INSTR;
                validD_o <= 1'b0;
            end else begin
                pc <= pc + 1'b1;
                if (flush_IF_ID_i) begin
                    PCD_o    <= '0;
                    instrD_o <= NOP_INSTR;
                    validD_o <= 1'b0;
                end else begin
                    PCD_o    <= pc;
                    instrD_o <= imem_rdata_i;
                    validD_o <= 1'b1;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = (state == RUN) && !branch_taken_i && !stall_IF_ID_i && !stop_i
                       && !jump_i && !flush_IF_ID_i;
    assign stall_evt = (state == RUN) && stall_IF_ID_i && !branch_taken_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (fetch_evt && fetch_cnt_o != '1)
                fetch_cnt_o <= fetch_cnt_o + 16'd1;
            if (stall_evt && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`else
    assign fetch_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of single-cycle vectors plus hand-written
// stall, halt and asynchronous-reset sequences.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        stall, flush, jump, branch, stop;
    logic [7:0]  jump_addr, branch_target;
    logic [7:0]  pcd;
    logic [15:0] instr_d;
    logic        valid_d, halted;
    logic [15:0] fetch_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    if_stage #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .RESET_PC  (8'h00),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr_o    (imem_addr),
        .imem_rdata_i   (imem_rdata),
        .stall_IF_ID_i  (stall),
        .flush_IF_ID_i  (flush),
        .jump_i         (jump),
        .jump_addr_i    (jump_addr),
        .branch_taken_i (branch),
        .branch_target_i(branch_target),
        .stop_i         (stop),
        .PCD_o          (pcd),
        .instrD_o       (instr_d),
        .validD_o       (valid_d),
        .halted_o       (halted),
        .fetch_cnt_o    (fetch_cnt),
        .stall_cnt_o    (stall_cnt)
    );

    // Instruction memory: mem[i] = 16'h1000 + i
    assign imem_rdata = 16'h1000 + {8'h00, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stall, flush, jump;
        logic [7:0] jaddr;
        logic       br;
        logic [7:0] btgt;
        logic       stop;
        logic [7:0] e_pc, e_pcd;
        logic [15:0] e_instr;
        logic       e_valid, e_halt;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] e_pc, input logic [7:0] e_pcd,
                             input logic [15:0] e_instr, input logic e_valid, input logic e_halt);
        chk({tag, ".pc"},     {24'h0, imem_addr}, {24'h0, e_pc});
        chk({tag, ".pcd"},    {24'h0, pcd},       {24'h0, e_pcd});
        chk({tag, ".instr"},  {16'h0, instr_d},   {16'h0, e_instr});
        chk({tag, ".valid"},  {31'h0, valid_d},   {31'h0, e_valid});
        chk({tag, ".halted"}, {31'h0, halted},    {31'h0, e_halt});
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] e_fetch, input logic [15:0] e_stall);
`ifdef IF_PERF_CNT_EN
        chk({tag, ".fetch_cnt"}, {16'h0, fetch_cnt}, {16'h0, e_fetch});
        chk({tag, ".stall_cnt"}, {16'h0, stall_cnt}, {16'h0, e_stall});
`else
        chk({tag, ".fetch_cnt"}, {16'h0, fetch_cnt}, 32'h0);
        chk({tag, ".stall_cnt"}, {16'h0, stall_cnt}, 32'h0);
        if (e_fetch == 16'hFFFF && e_stall == 16'hFFFF) $display("unexpected counter request");
`endif
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; jump = 1'b0; branch = 1'b0; stop = 1'b0;
        jump_addr = 8'h00; branch_target = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle rows are written compactly: {stall,flush,jump,jaddr,br,btgt,stop, pc,pcd,instr,valid,halt}
        tbl[0]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h01,8'h00,16'h1000,1'b1,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h02,8'h01,16'h1001,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h03,8'h02,16'h1002,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h04,8'h03,16'h1003,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h05,8'h04,16'h1004,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b1,8'h40,1'b0,8'h00,1'b0, 8'h40,8'h00,16'h0000,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h41,8'h40,16'h1040,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,8'h00,1'b1,8'h20,1'b0, 8'h20,8'h00,16'h0000,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h21,8'h20,16'h1020,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h22,8'h00,16'h0000,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h23,8'h22,16'h1022,1'b1,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h23,8'h00,16'h0000,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h24,8'h23,16'h1023,1'b1,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,8'hFE,1'b0,8'h00,1'b0, 8'hFE,8'h00,16'h0000,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'hFF,8'hFE,16'h10FE,1'b1,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h00,8'hFF,16'h10FF,1'b1,1'b0};
        tbl[16] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h01,8'h00,16'h1000,1'b1,1'b0};
        tbl[17] = '{1'b0,1'b0,1'b0,8'h00,1'b1,8'h30,1'b1, 8'h30,8'h00,16'h0000,1'b0,1'b0};
        tbl[18] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h31,8'h30,16'h1030,1'b1,1'b0};
        tbl[19] = '{1'b1,1'b0,1'b1,8'h50,1'b0,8'h00,1'b0, 8'h31,8'h30,16'h1030,1'b1,1'b0};
        tbl[20] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 8'h32,8'h31,16'h1031,1'b1,1'b0};

        idle_inputs();
        rst = 1'b0;
        #12;
        chk_state("reset", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        chk_cnt("reset", 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush; jump = tbl[i].jump;
            jump_addr = tbl[i].jaddr; branch = tbl[i].br; branch_target = tbl[i].btgt;
            stop = tbl[i].stop;
            step();
            chk_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_pcd, tbl[i].e_instr,
                      tbl[i].e_valid, tbl[i].e_halt);
        end

        // Clean restart so counter expectations start from zero
        idle_inputs();
        rst = 1'b0;
        #1;
        chk_state("rst_run", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Stall for 3 cycles with PCD = 7
        jump = 1'b1; jump_addr = 8'h07;
        step();
        chk_state("to7", 8'h07, 8'h00, 16'h0000, 1'b0, 1'b0);
        idle_inputs();
        step();
        chk_state("pcd7", 8'h08, 8'h07, 16'h1007, 1'b1, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_state($sformatf("stall%0d", k), 8'h08, 8'h07, 16'h1007, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step();
        chk_state("unstall", 8'h09, 8'h08, 16'h1008, 1'b1, 1'b0);
        chk_cnt("unstall", 16'd2, 16'd3);

        // Asynchronous reset in the middle of a stall
        stall = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_state("rst_stall", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        chk_cnt("rst_stall", 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        step();
        chk_state("restart0", 8'h01, 8'h00, 16'h1000, 1'b1, 1'b0);
        step();
        chk_state("restart1", 8'h02, 8'h01, 16'h1001, 1'b1, 1'b0);

        // Stop held off by stall, then accepted
        stop = 1'b1; stall = 1'b1;
        step();
        chk_state("stop_stall", 8'h02, 8'h01, 16'h1001, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        chk_state("halt", 8'h02, 8'h00, 16'h0000, 1'b0, 1'b1);
        chk_cnt("halt", 16'd2, 16'd1);

        // Everything ignored in HALT
        stop = 1'b0; jump = 1'b1; jump_addr = 8'h40; branch = 1'b1; branch_target = 8'h20;
        flush = 1'b1; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_state($sformatf("halt_hold%0d", k), 8'h02, 8'h00, 16'h0000, 1'b0, 1'b1);
        end
        chk_cnt("halt_hold", 16'd2, 16'd1);

        // Asynchronous reset out of HALT
        rst = 1'b0;
        #1;
        chk_state("rst_halt", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        step();
        chk_state("post_halt", 8'h01, 8'h00, 16'h1000, 1'b1, 1'b0);
        chk_cnt("post_halt", 16'd1, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined processor, sitting directly upstream of the decode stage. It owns the program counter, drives the instruction-memory read address, and selects the next PC from sequential, jump (ID) and taken-branch (EX) sources. It holds the IF/ID pipeline register that feeds decode with the fetched word and its PC, and it applies the hazard unit's stall/flush plus a halt state machine triggered by the Stop decode.

## Interface
- DATA_WIDTH, 16, instruction width
- ADDR_WIDTH, 8, PC / instruction-memory address width
- RESET_PC, 0, first fetch address after reset
- NOP_INSTR, 16'h0000, word placed in IF/ID on reset, flush or halt
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- imem_addr_o  output  ADDR_WIDTH  instruction-memory read address (= PC register)
- imem_rdata_i  input  DATA_WIDTH  instruction word for imem_addr_o, same cycle (combinational read)
- stall_IF_ID_i  input  1  hazard unit: hold PC and IF/ID
- flush_IF_ID_i  input  1  hazard unit: load NOP into IF/ID
- jump_i  input  1  ID decoded Jump
- jump_addr_i  input  ADDR_WIDTH  jump target from ID
- branch_taken_i  input  1  EX resolved taken branch
- branch_target_i  input  ADDR_WIDTH  branch target from EX
- stop_i  input  1  ID decoded Stop
- PCD_o  output  ADDR_WIDTH  PC of instruction in IF/ID
- instrD_o  output  DATA_WIDTH  instruction in IF/ID
- validD_o  output  1  IF/ID holds a real fetched instruction
- halted_o  output  1  FSM in HALT
- fetch_cnt_o  output  16  fetched-instruction count (see Configuration)
- stall_cnt_o  output  16  stall-cycle count (see Configuration)

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- Next-PC priority in RUN (highest first): branch_taken_i → branch_target_i; stall_IF_ID_i → hold; jump_i → jump_addr_i; else PC+1.
- PC+1 is modulo 2^ADDR_WIDTH: 8'hFF wraps to 8'h00.
- IF/ID update priority: branch_taken_i or flush_IF_ID_i → {NOP_INSTR, PCD 0, valid 0}; stall_IF_ID_i → hold; jump_i → NOP (wrong-path fetch squashed); else {imem_rdata_i, PC, valid 1}.
- Branch and stall together: branch wins (PC redirects, IF/ID flushed).
- stop_i in RUN with no branch_taken_i → HALT next edge; PC holds, IF/ID loads NOP, valid 0.
- stop_i and branch_taken_i same cycle: Stop is wrong-path; remain RUN, branch taken.
- stop_i during stall_IF_ID_i: ignored until stall drops (Stop instruction still held in ID).
- HALT: PC frozen, IF/ID held at NOP, all redirect/stall/flush inputs ignored; exit only via rst.

## Timing
- Reset (rst=0, async): PC=RESET_PC, instrD_o=NOP_INSTR, PCD_o=0, validD_o=0, halted_o=0, both counters 0, FSM=RUN.
- First edge after rst release: IF/ID = {mem[RESET_PC], RESET_PC, 1}; fetch latency 1 cycle.
- Redirect at cycle N (branch or jump): PC=target after edge N; target instruction in IF/ID after edge N+1; one bubble for jump, one for branch at IF/ID (ID/EX flush is the hazard unit's job).
- stall_IF_ID_i high for k cycles: PC and IF/ID frozen exactly k cycles, no fetch lost.
- halted_o asserts the edge after the accepted stop_i.
- All outputs registered except imem_addr_o (direct from PC register).

## Configuration
- IF_PERF_CNT_EN defined: fetch_cnt_o increments on each edge loading valid 1 into IF/ID; stall_cnt_o increments each RUN cycle with stall_IF_ID_i high and no branch_taken_i; both saturate at 16'hFFFF, reset to 0, frozen in HALT.
- Undefined: counter registers not built; fetch_cnt_o and stall_cnt_o tied to 0.

## Test plan
- Reset then free-run on mem[i]=16'h1000+i: after 3 edges PCD_o=2, instrD_o=16'h1002, validD_o=1; PC 8'hFF → 8'h00 wrap verified.
- jump_i=1, jump_addr_i=8'h40 at PC=5: next IF/ID NOP/valid 0, following IF/ID PCD_o=8'h40.
- branch_taken_i=1, target 8'h20, with stall_IF_ID_i=1 same cycle: PC=8'h20, IF/ID flushed; stall ignored.
- stall_IF_ID_i 3 cycles at PCD_o=7: PCD_o stays 7 for 3 cycles, then 8; stall_cnt_o=3 (with IF_PERF_CNT_EN).
- stop_i=1 alone: halted_o=1 next edge, PC frozen, further jump/branch ignored; stop_i with branch_taken_i: halted_o stays 0.
- rst pulled low mid-HALT and mid-stall: outputs return to reset values immediately (async), fetch restarts at RESET_PC.
